// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte-stream input and instruction-memory write port bundle for inst_loader
// master = loader side (accepts bytes, drives writes); slave = stream source / memory side.
interface inst_loader_if;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic [31:0] WriteAddr;
  logic [31:0] WriteData;
  logic        WriteEnable;

  modport master (
    input  ByteIn, ByteValid,
    output ByteReady, WriteAddr, WriteData, WriteEnable
  );

  modport slave (
    output ByteIn, ByteValid,
    input  ByteReady, WriteAddr, WriteData, WriteEnable
  );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot loader: big-endian byte stream -> 32-bit instruction-memory writes
// Optional trailing XOR checksum byte enabled by INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start,
  inst_loader_if.master bus,
  output logic         CpuHold,
  output logic         Done,
  output logic [31:0]  LoadCount,
  output logic         Overflow,
  output logic         ChkErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_e;

  localparam logic [31:0] MemWords = 32'(MEM_WORDS);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_e TailState = S_CHK;
`else
  localparam state_e TailState = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic        ovf_q, ovf_d;
  logic        xfer;
  logic [31:0] word;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        chk_q, chk_d;
`endif

  // ready_q mirrors the byte-accepting states, so xfer never depends on a comb path
  assign xfer = bus.ByteValid && ready_q;
  assign word = {shift_q, bus.ByteIn};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    load_cnt_d = load_cnt_q;
    ovf_d      = ovf_q;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          shift_d    = 24'd0;
          idx_d      = 32'd0;
          addr_d     = BASE_ADDR;
          load_cnt_d = 32'd0;
          ovf_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d      = 8'd0;
          chk_d      = 1'b0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          shift_d    = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.ByteIn;
`endif
          if (byte_cnt_q == 2'd3) begin
            count_d = word;
            ovf_d   = (word > MemWords);
            state_d = (word == 32'd0) ? TailState : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d    = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.ByteIn;
`endif
          if (byte_cnt_q == 2'd3) begin
            wdata_d = word;
            we_d    = (idx_q < MemWords);
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // words past capacity are still consumed, only the strobe is withheld
        addr_d  = addr_q + 32'd4;
        idx_d   = idx_q + 32'd1;
        if (we_q) load_cnt_d = load_cnt_q + 32'd1;
        state_d = ((idx_q + 32'd1) == count_q) ? TailState : S_DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (bus.ByteIn != xor_q) chk_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_HDR) || (state_d == S_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CHK);
`endif
    hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      count_q    <= 32'd0;
      idx_q      <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      load_cnt_q <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      load_cnt_q <= load_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      xor_q <= 8'd0;
      chk_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      chk_q <= chk_d;
    end
  end
  assign ChkErr = chk_q;
`else
  assign ChkErr = 1'b0;
`endif

  assign bus.ByteReady   = ready_q;
  assign bus.WriteAddr   = addr_q;
  assign bus.WriteData   = wdata_q;
  assign bus.WriteEnable = we_q;
  assign CpuHold         = hold_q;
  assign Done            = done_q;
  assign LoadCount       = load_cnt_q;
  assign Overflow        = ovf_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader with random loads and gaps
// Expected writes are queued per load; a negedge monitor pops and compares every WriteEnable.
module tb_inst_loader;
  localparam logic [31:0] BASE = 32'h0;
  localparam int MEMW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, done, overflow, chk_err;
  logic [31:0] load_count;

  inst_loader_if bus();

  inst_loader #(.BASE_ADDR(BASE), .MEM_WORDS(MEMW)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .bus(bus),
    .CpuHold(cpu_hold), .Done(done), .LoadCount(load_count),
    .Overflow(overflow), .ChkErr(chk_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.WriteEnable === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 bus.WriteAddr, bus.WriteData);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", bus.WriteAddr, e.addr);
        check("write_data", bus.WriteData, e.data);
      end
      check("ready_low_in_write", {31'd0, bus.ByteReady}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      if (g != 0) begin
        bus.ByteValid = 1'b0;
        bus.ByteIn = 8'($urandom);
        repeat (g) @(negedge clk);
      end
    end
    bus.ByteIn = b;
    bus.ByteValid = 1'b1;
    waited = 0;
    while (bus.ByteReady !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ByteReady !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: got ByteReady=0 for 50 cycles expected 1");
      return;
    end
    @(negedge clk);
  endtask

  task automatic run_load(input int n, input bit gaps, input bit noise, input logic [7:0] mask);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] nn;
    logic [31:0] w;
    logic        chk_exp;
    wr_t         e;
    int          exp_cnt;
    int          waited;
    nn = 32'(n);
    x = 8'd0;
    exp_cnt = 0;
    for (int k = 3; k >= 0; k--) bytes.push_back(nn[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) bytes.push_back(w[8*k +: 8]);
      if (i < MEMW) begin
        e.addr = BASE + 32'(4 * i);
        e.data = w;
        exp_q.push_back(e);
        exp_cnt++;
      end
    end
    foreach (bytes[j]) x ^= bytes[j];
    chk_exp = (mask != 8'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    bytes.push_back(x ^ mask);
`else
    chk_exp = 1'b0;
`endif

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("count_cleared", load_count, 32'd0);

    for (int j = 0; j < bytes.size(); j++) begin
      if (noise && j == 2) start = 1'b1;
      send_byte(bytes[j], gaps);
      start = 1'b0;
    end
    bus.ByteValid = 1'b0;

    waited = 0;
    while (done !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    check("load_count", load_count, 32'(exp_cnt));
    check("overflow", {31'd0, overflow}, {31'd0, (nn > 32'(MEMW))});
    check("chk_err", {31'd0, chk_err}, {31'd0, chk_exp});
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("done_sticky", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ByteIn = 8'h00;
    bus.ByteValid = 1'b0;

    #12;
    check("rst_ready", {31'd0, bus.ByteReady}, 32'd0);
    check("rst_we", {31'd0, bus.WriteEnable}, 32'd0);
    check("rst_addr", bus.WriteAddr, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, bus.ByteReady}, 32'd0);

    words = '{32'h12345678, 32'h9ABCDEF0};
    run_load(2, 1'b0, 1'b0, 8'h00);

    words.delete();
    run_load(0, 1'b0, 1'b0, 8'h00);

    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_load(3, 1'b1, 1'b0, 8'h00);

    words = '{32'h01020304};
    run_load(1, 1'b0, 1'b0, 8'h00);
    run_load(1, 1'b0, 1'b0, 8'h03);

    repeat (10) begin
      n = $urandom_range(0, 4);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
    end

    // abort mid-DATA: header N=2 plus two data bytes, then async reset
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bus.ByteIn = 8'hCC;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.ByteReady}, 32'd0);
    check("mid_rst_we", {31'd0, bus.WriteEnable}, 32'd0);
    check("mid_rst_addr", bus.WriteAddr, 32'd0);
    check("mid_rst_data", bus.WriteData, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_count", load_count, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_chk", {31'd0, chk_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_ready", {31'd0, bus.ByteReady}, 32'd0);
    check("post_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    bus.ByteValid = 1'b0;

    repeat (3) @(negedge clk);
    check("final_outstanding", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer end of the instruction-memory write port: receives a byte stream over a valid/ready handshake and drives WriteAddr/WriteData/WriteEnable into the instruction memory.
- Assembles 4 bytes into one 32-bit word (big-endian, MIPS order).
- Holds the CPU via CpuHold while loading and signals Done on completion. Used as the boot path that fills instruction memory before the PC runs.

Parameters:
- BASE_ADDR, 0, byte address of the first word written; word-aligned.
- MEM_WORDS, 1024, instruction-memory capacity in words; writes beyond this are suppressed.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a load; honoured only in IDLE or DONE.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn valid.
- ByteReady  out  1  loader can accept a byte this cycle.
- WriteAddr  out  32  byte address to instruction memory.
- WriteData  out  32  assembled instruction word.
- WriteEnable  out  1  one-cycle write strobe.
- CpuHold  out  1  keep PC/CPU stalled.
- Done  out  1  load finished; sticky until the next Start.
- LoadCount  out  32  words actually written this load.
- Overflow  out  1  header count exceeded MEM_WORDS.
- ChkErr  out  1  checksum mismatch; tied 0 without the macro.

Behaviour:
- Reset (async, Rst_n=0): state IDLE; every output 0; byte counter, word counter, address, and shift register cleared. Reset mid-load aborts the load immediately; no further WriteEnable is issued.
- Byte transfer: occurs on a posedge with ByteValid=1 and ByteReady=1. ByteReady is a registered function of state: 1 in HDR, DATA, and CHK; 0 otherwise.
- Stream format: 4-byte big-endian word count N, then N×4 data bytes, then (with the macro only) one checksum byte.
- IDLE: Start=1 -> HDR, CpuHold<=1, Done<=0, LoadCount<=0, Overflow<=0, ChkErr<=0, address<=BASE_ADDR.
- HDR: shift in 4 bytes (first byte = bits 31:24).
  - After the 4th byte: N==0 -> CHK if macro enabled, else DONE.
  - Otherwise -> DATA.
  - N>MEM_WORDS -> Overflow<=1.
- DATA: shift in 4 bytes. After the 4th, register WriteData and go to WRITE.
- WRITE: exactly one cycle.
  - WriteEnable=1 with the current WriteAddr, only if the word index < MEM_WORDS; otherwise WriteEnable stays 0 and the word is discarded.
  - LoadCount increments only on an actual write.
  - Next cycle: WriteAddr+=4; word index+1.
  - Index==N -> CHK or DONE; else DATA.
- Per-word latency: 4 accepted bytes plus 1 WRITE cycle, so ByteReady drops for one cycle per word.
- WriteAddr arithmetic: modulo 2^32 wrap. Never reached with a legal MEM_WORDS.
- DONE: CpuHold=0, Done=1. Start=1 -> restart as from IDLE (same cycle transition into HDR).
- Start in HDR/DATA/WRITE/CHK is ignored.
- ByteValid with ByteReady=0 is not consumed; the source holds the byte.
- Outputs change only on Clk edges or async reset; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Enabled:
  - Running 8-bit XOR over all header and data bytes, cleared on Start.
  - State CHK accepts one byte; if it differs from the running XOR, ChkErr<=1.
  - Then DONE; Done asserts regardless of ChkErr.
  - Memory writes already made are not undone.
- Disabled: no CHK state, no XOR logic, ChkErr constant 0, DONE entered directly after the last WRITE.

Test Plan:
- Reset mid-DATA: Rst_n pulsed low after 6 bytes -> outputs 0 immediately, state IDLE, no WriteEnable afterward.
- Basic load, BASE_ADDR=0:
  - Start, then bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0.
  - Required: WriteEnable pulses with (0x0, 0x12345678) then (0x4, 0x9ABCDEF0); LoadCount=2; Done=1; CpuHold=0 after.
- Zero count: header 00 00 00 00 -> no WriteEnable; Done=1; LoadCount=0.
- Back-pressure/gaps:
  - ByteValid toggled randomly -> identical writes.
  - ByteReady=0 in each WRITE cycle.
  - No byte lost or duplicated.
- Overflow, MEM_WORDS=2: header N=3 with 3 words.
  - Overflow=1; exactly 2 writes (addresses 0x0, 0x4); third word consumed but not written; LoadCount=2; Done=1.
- Checksum (macro on): N=1, word 01 02 03 04.
  - Trailer byte 0x05 (XOR of 00 00 00 01 01 02 03 04) -> ChkErr=0.
  - Repeat with 0x06 -> ChkErr=1, Done=1.
